// File: rtl/double_to_sig16b_pkg.sv
`default_nettype none
// ============================================================================
// Module      : double_to_sig16b_pkg
// Description : Shared constants and types for the binary64 -> 16-bit
//               sign-magnitude sample converter.
// Revision    : 1.0 - initial release
// ============================================================================
package double_to_sig16b_pkg;

    localparam int          DOUBLE_BIAS = 1023;
    localparam int          EXP_W       = 11;
    localparam int          FRAC_W      = 52;
    localparam int          SAMPLE_W    = 16;
    localparam logic [14:0] MAG_MAX     = 15'h7FFF;
    localparam int          CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Operand classes as seen by the converter
    typedef enum logic [1:0] {
        CLS_ZERO   = 2'd0,  // zero, subnormal or |x| < 1.0
        CLS_NAN    = 2'd1,
        CLS_MAX    = 2'd2,  // infinity or |x| >= 32768.0
        CLS_NORMAL = 2'd3   // 1.0 <= |x| < 32768.0
    } class_t;

endpackage
`default_nettype wire

// File: rtl/double_to_sig16b_if.sv
`default_nettype none
// ============================================================================
// Module      : double_to_sig16b_if
// Description : Request/result bundle of the converter.
//               start/double : conversion request and operand (master drives)
//               sig16b/sat   : result sample and saturation flag
//               busy/done    : status and one-cycle result-valid pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface double_to_sig16b_if;
    logic        start;
    logic [63:0] double;
    logic [15:0] sig16b;
    logic        busy;
    logic        done;
    logic        sat;

    modport master (output start, double, input  sig16b, busy, done, sat);
    modport slave  (input  start, double, output sig16b, busy, done, sat);
endinterface
`default_nettype wire

// File: rtl/double_classify.sv
`default_nettype none
// ============================================================================
// Module      : double_classify
// Description : Combinational classification of a binary64 operand.
//   i_double : operand
//   o_class  : zero/small, NaN, saturating, or normal in-range
//   o_count  : right-shift count 15-e (meaningful for CLS_NORMAL only)
//   o_sign   : operand sign bit
// Revision    : 1.0 - initial release
// ============================================================================
module double_classify
    import double_to_sig16b_pkg::*;
(
    input  wire logic [63:0]      i_double,
    output class_t                o_class,
    output logic [CNT_W-1:0]      o_count,
    output logic                  o_sign
);

    logic [EXP_W-1:0]  w_exp_b;
    logic [FRAC_W-1:0] w_frac;
    logic [11:0]       w_e;     // signed unbiased exponent

    assign w_exp_b = i_double[62:52];
    assign w_frac  = i_double[51:0];
    assign w_e     = {1'b0, w_exp_b} - 12'(DOUBLE_BIAS);
    assign o_sign  = i_double[63];
    // Only valid for 0 <= e <= 14, where the low nibble alone suffices
    assign o_count = 4'd15 - w_e[3:0];

    always_comb begin
        o_class = CLS_NORMAL;
        if (w_exp_b == '1) begin
            o_class = (w_frac != '0) ? CLS_NAN : CLS_MAX;
        end else if ((w_exp_b == '0) || w_e[11]) begin
            o_class = CLS_ZERO;
        end else if (w_e >= 12'd15) begin
            o_class = CLS_MAX;
        end
    end

endmodule
`default_nettype wire

// File: rtl/double_to_sig16b.sv
`default_nettype none
// ============================================================================
// Module      : double_to_sig16b
// Description : Converts an IEEE-754 binary64 operand into a 16-bit
//               sign-magnitude sample, truncating toward zero and clamping
//               to +/-0x7FFF. In-range values are scaled by a serial right
//               shifter, one bit per cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request/result bundle (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module double_to_sig16b
    import double_to_sig16b_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst,
    double_to_sig16b_if.slave  bus
);

    state_t                r_state;
    state_t                w_next_state;
    logic [SAMPLE_W-1:0]   r_shift;
    logic [CNT_W-1:0]      r_count;
    logic                  r_sign;
    logic [SAMPLE_W-1:0]   r_sig16b;
    logic                  r_sat;

    class_t                w_class;
    logic [CNT_W-1:0]      w_count;
    logic                  w_sign;
    logic                  w_accept;
    logic                  w_last;
    logic [SAMPLE_W-1:0]   w_shifted;

    double_classify u_classify (
        .i_double (bus.double),
        .o_class  (w_class),
        .o_count  (w_count),
        .o_sign   (w_sign)
    );

    assign w_accept  = (r_state == ST_IDLE) && bus.start;
    assign w_last    = (r_count == 4'd1);
    assign w_shifted = r_shift >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_next_state = (w_class == CLS_NORMAL) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Result registers change only on the edge that enters DONE, so they
    // stay stable through SHIFT and hold afterwards until the next result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift  <= '0;
            r_count  <= '0;
            r_sign   <= 1'b0;
            r_sig16b <= '0;
            r_sat    <= 1'b0;
        end else if (w_accept) begin
            r_sign <= w_sign;
            case (w_class)
                CLS_ZERO: begin
                    r_sig16b <= '0;
                    r_sat    <= 1'b0;
                end
                CLS_NAN: begin
                    r_sig16b <= '0;
                    r_sat    <= 1'b1;
                end
                CLS_MAX: begin
                    r_sig16b <= {w_sign, MAG_MAX};
                    r_sat    <= 1'b1;
                end
                default: begin
                    // Implicit leading one plus the top 15 fraction bits;
                    // shifting right by 15-e leaves floor(|x|).
                    r_shift <= {1'b1, bus.double[51:37]};
                    r_count <= w_count;
                end
            endcase
        end else if (r_state == ST_SHIFT) begin
            r_shift <= w_shifted;
            r_count <= r_count - 4'd1;
            if (w_last) begin
                // Suppress negative zero
                r_sig16b <= {r_sign & (|w_shifted[14:0]), w_shifted[14:0]};
                r_sat    <= 1'b0;
            end
        end
    end

    assign bus.sig16b = r_sig16b;
    assign bus.sat    = r_sat;
    assign bus.done   = (r_state == ST_DONE);
    assign bus.busy   = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_double_to_sig16b.sv
`default_nettype none
// ============================================================================
// Module      : tb_double_to_sig16b
// Description : Self-checking bench for double_to_sig16b. Directed vector
//               table, reset-abort sequences and randomized back-to-back
//               conversions against a real-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_double_to_sig16b;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    double_to_sig16b_if bus ();

    double_to_sig16b dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic [15:0] sig;
        logic        sat;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference: value semantics of the conversion using real arithmetic
    function automatic void model(input logic [63:0] d, output logic [15:0] s,
                                  output logic sat, output int lat);
        real    a;
        longint m;
        int     hb;
        s = '0; sat = 1'b0; lat = 1;
        if (d[62:52] == 11'h7FF) begin
            sat = 1'b1;
            s   = (d[51:0] != 52'd0) ? 16'h0000 : {d[63], 15'h7FFF};
            return;
        end
        a = $bitstoreal(d);
        if (a < 0.0) a = -a;
        if (a >= 32768.0) begin
            sat = 1'b1;
            s   = {d[63], 15'h7FFF};
            return;
        end
        m = $rtoi(a);
        if (m == 0) return;
        hb = 0;
        for (int i = 0; i < 15; i++) if (m[i]) hb = i;
        s   = {d[63], m[14:0]};
        lat = 16 - hb;
    endfunction

    // Called at a negedge with the DUT idle. hold keeps start high throughout.
    task automatic do_conv(input logic [63:0] d, input bit hold, input logic [15:0] es,
                           input logic esat, input int elat, input string tag);
        bit          got;
        int          lat;
        logic [63:0] junk;
        bus.start  = 1'b1;
        bus.double = d;
        @(posedge clk);
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                lat = k;
            end else begin
                if (!hold) bus.start = 1'b0;
                junk = {$urandom, $urandom};
                bus.double = junk;
            end
        end
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL %s timeout waiting for done", tag);
        end else begin
            chk({tag, " sig16b"}, {48'd0, bus.sig16b}, {48'd0, es});
            chk({tag, " sat"}, {63'd0, bus.sat}, {63'd0, esat});
            chk({tag, " latency"}, 64'(lat), 64'(elat));
            chk({tag, " busy@done"}, {63'd0, bus.busy}, 64'd1);
        end
        if (!hold) bus.start = 1'b0;
        junk = {$urandom, $urandom};
        bus.double = junk;
        @(negedge clk);
        chk({tag, " done width"}, {63'd0, bus.done}, 64'd0);
        chk({tag, " idle after"}, {63'd0, bus.busy}, 64'd0);
        chk({tag, " sig hold"}, {48'd0, bus.sig16b}, {48'd0, es});
    endtask

    vec_t        tbl [8];
    logic [15:0] ms;
    logic        msat;
    int          mlat;
    logic [63:0] rd;
    logic [51:0] rf;
    int          done_seen;

    initial begin
        n_vec = 0;
        n_err = 0;
        tbl[0] = '{64'h3FF0000000000000, 16'h0001, 1'b0, 16};
        tbl[1] = '{64'hC00E000000000000, 16'h8003, 1'b0, 15};
        tbl[2] = '{64'h40DFFFC000000000, 16'h7FFF, 1'b0, 2};
        tbl[3] = '{64'h40E0000000000000, 16'h7FFF, 1'b1, 1};
        tbl[4] = '{64'hC0E0000000000000, 16'hFFFF, 1'b1, 1};
        tbl[5] = '{64'hBFE0000000000000, 16'h0000, 1'b0, 1};
        tbl[6] = '{64'h8000000000000000, 16'h0000, 1'b0, 1};
        tbl[7] = '{64'h7FF8000000000000, 16'h0000, 1'b1, 1};

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.double = '0;
        repeat (3) @(negedge clk);
        chk("reset sig16b", {48'd0, bus.sig16b}, 64'd0);
        chk("reset sat", {63'd0, bus.sat}, 64'd0);
        chk("reset done", {63'd0, bus.done}, 64'd0);
        chk("reset busy", {63'd0, bus.busy}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            do_conv(tbl[i].d, 1'b0, tbl[i].sig, tbl[i].sat, tbl[i].lat,
                    $sformatf("vec%0d", i));
        end

        // Leave non-zero results behind, then abort a 1.0 conversion
        do_conv(64'hFFF0000000000000, 1'b0, 16'hFFFF, 1'b1, 1, "ninf");
        bus.start  = 1'b1;
        bus.double = 64'h3FF0000000000000;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        done_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        chk("abort no done", 64'(done_seen), 64'd0);
        chk("abort sig16b", {48'd0, bus.sig16b}, 64'd0);
        chk("abort sat", {63'd0, bus.sat}, 64'd0);
        chk("abort busy", {63'd0, bus.busy}, 64'd0);

        // start coincident with rst is ignored
        rst        = 1'b1;
        bus.start  = 1'b1;
        bus.double = 64'h7FF0000000000000;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        chk("start with rst busy", {63'd0, bus.busy}, 64'd0);
        chk("start with rst done", {63'd0, bus.done}, 64'd0);
        chk("start with rst sat", {63'd0, bus.sat}, 64'd0);
        do_conv(64'h3FF0000000000000, 1'b0, 16'h0001, 1'b0, 16, "post-abort 1.0");

        // Randomized conversions with start held high throughout
        for (int i = 0; i < 60; i++) begin
            rf = {$urandom, $urandom};
            rd[63] = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       rd[62:52] = 11'd0;
                1:       rd[62:52] = 11'h7FF;
                2:       begin rd[62:52] = 11'h7FF; rf = '0; end
                default: rd[62:52] = 11'(1021 + $urandom_range(0, 18));
            endcase
            rd[51:0] = rf;
            model(rd, ms, msat, mlat);
            do_conv(rd, 1'b1, ms, msat, mlat, $sformatf("rnd%0d", i));
        end
        bus.start = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/double_to_sig16b.md
DOUBLE_TO_SIG16B -- requirements
Module: double_to_sig16b

Interface
REQ-001 SHALL have clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have rst, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have start, input, 1, request to convert double; sampled only in IDLE.
REQ-004 SHALL have double, input, 64, IEEE-754 binary64 operand; sign [63], biased exponent [62:52], fraction [51:0]; captured on accepted start.
REQ-005 SHALL have sig16b, output, 16, sign-magnitude sample; sign [15], magnitude [14:0].
REQ-006 SHALL have busy, output, 1, high whenever state is not IDLE.
REQ-007 SHALL have done, output, 1, single-cycle pulse marking sig16b valid.
REQ-008 SHALL have sat, output, 1, result clamped or operand invalid; valid with done, held until next accept.

Function
REQ-009 SHALL implement FSM states IDLE, SHIFT, DONE; DONE always returns to IDLE next cycle.
REQ-010 SHALL accept start only in IDLE; start while busy is ignored with no effect.
REQ-011 On accept, SHALL compute unbiased exponent e = E - 1023 (signed, 12-bit).
REQ-012 SHALL classify: E==0 (zero/subnormal) or e<0 -> magnitude 0, sat=0, go to DONE.
REQ-013 SHALL classify: E==2047 with fraction!=0 (NaN) -> sig16b=0x0000, sat=1, go to DONE.
REQ-014 SHALL classify: E==2047 with fraction==0 (infinity) or e>=15 -> magnitude 0x7FFF, sign kept, sat=1, go to DONE.
REQ-015 Otherwise (0<=e<=14) SHALL load a 16-bit shifter with {1'b1, fraction[51:37]}, load count = 15-e, go to SHIFT.
REQ-016 In SHIFT SHALL logical-right-shift by one bit and decrement count each cycle; on the cycle count==1, SHALL go to DONE.
REQ-017 Rounding SHALL be truncation toward zero; fraction bits [36:0] are discarded.
REQ-018 In DONE, sig16b SHALL present {sign, shifter[14:0]}, with sign forced 0 when magnitude is 0 (no negative zero).
REQ-019 Latency SHALL be: special classes -> done in cycle 1 after the accept cycle; normal -> done in cycle 16-e (e=14 -> 2, e=0 -> 16).
REQ-020 sig16b and sat SHALL hold their last value from DONE until the next accept; they SHALL not glitch during SHIFT.
REQ-021 done SHALL be high exactly one cycle per accepted start.

Reset
REQ-022 rst SHALL force state IDLE, sig16b=0x0000, sat=0, done=0, busy=0, count=0, shifter=0.
REQ-023 rst asserted during SHIFT or DONE SHALL abort the conversion; no done pulse issues for it.
REQ-024 start sampled in the same cycle as rst SHALL be ignored.

Structure
REQ-025 Shared package SHALL hold DOUBLE_BIAS=1023, EXP_W=11, FRAC_W=52, SAMPLE_W=16, MAG_MAX=15'h7FFF and the FSM state enum.
REQ-026 Operand classification (zero/normal/inf/NaN, e range) SHALL be a combinational sub-module double_classify; the shifter and FSM stay in double_to_sig16b.

Verification
REQ-027 0x3FF0000000000000 (1.0) -> sig16b=0x0001, sat=0, done 16 cycles after accept.
REQ-028 0xC00E000000000000 (-3.75) -> sig16b=0x8003, sat=0, done 15 cycles after accept.
REQ-029 0x40DFFFC000000000 (32767.0) -> 0x7FFF, sat=0, done at cycle 2; 0x40E0000000000000 (32768.0) -> 0x7FFF, sat=1, done at cycle 1; 0xC0E0000000000000 -> 0xFFFF, sat=1.
REQ-030 0xBFE0000000000000 (-0.5) -> 0x0000, sat=0; 0x8000000000000000 (-0.0) -> 0x0000; 0x7FF8000000000000 (NaN) -> 0x0000, sat=1.
REQ-031 start held high continuously with changing operands -> one done per conversion, each result matches the operand present at its accept cycle.
REQ-032 rst asserted 3 cycles into a 1.0 conversion -> no done pulse, outputs 0; a following start converts correctly.
